pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/rv_constants.sv | 16 +
 rtl/pc_next_select.sv | 30 +++
 rtl/pc_fetch.sv | 86 ++++++++
 tb/tb_pc_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_constants.sv
// Shared RV core constants: next-PC select encodings and fetch FSM states.
package rv_constants;

  localparam logic [1:0] PC_SOURCE_NEXT   = 2'd0;
  localparam logic [1:0] PC_SOURCE_BRANCH = 2'd1;
  localparam logic [1:0] PC_SOURCE_JAL    = 2'd2;
  localparam logic [1:0] PC_SOURCE_JALR   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-PC mux with link value and alignment check.
module pc_next_select
  import rv_constants::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_source,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_plus_4,
  output logic [31:0] next_pc,
  output logic        aligned
);

  assign pc_plus_4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus_4;
    unique case (pc_source)
      PC_SOURCE_NEXT:   next_pc = pc_plus_4;
      PC_SOURCE_BRANCH: next_pc = take_branch ? branch_target : pc_plus_4;
      PC_SOURCE_JAL:    next_pc = branch_target;
      PC_SOURCE_JALR:   next_pc = {jalr_target[31:1], 1'b0};
      default:          next_pc = pc_plus_4;
    endcase
  end

  assign aligned = (next_pc[1:0] == 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, imem handshake FSM and held instruction.
module pc_fetch
  import rv_constants::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        take_branch,
  input  logic [1:0]  pc_source,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        misaligned_trap
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         aligned;

  pc_next_select u_sel (
    .pc            (pc),
    .pc_source     (pc_source),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .pc_plus_4     (pc_plus_4),
    .next_pc       (next_pc),
    .aligned       (aligned)
  );

  assign imem_addr = pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      pc              <= RESET_VECTOR;
      inst            <= 32'h0;
      imem_req        <= 1'b0;
      inst_valid      <= 1'b0;
      misaligned_trap <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            state      <= ST_VALID;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (retire) begin
            inst_valid <= 1'b0;
            if (aligned) begin
              pc       <= next_pc;
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              misaligned_trap <= 1'b1;
              state           <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table plus corner sequences.
module tb_pc_fetch;
  import rv_constants::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        take_branch;
  logic [1:0]  pc_source;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        misaligned_trap;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  src;
    logic        take;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] exp;
    int          delay;
  } vec_t;

  vec_t vecs[11];

  pc_fetch dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .take_branch     (take_branch),
    .pc_source       (pc_source),
    .branch_target   (branch_target),
    .jalr_target     (jalr_target),
    .retire          (retire),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .pc              (pc),
    .pc_plus_4       (pc_plus_4),
    .misaligned_trap (misaligned_trap)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold imem_ready low for d cycles, then accept and check the held word.
  task automatic serve(input int d, input logic [31:0] a);
    logic [31:0] e;
    for (int i = 0; i < d; i++) begin
      imem_ready = 1'b0;
      step();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, a);
      chk("stall_inst_valid", {31'b0, inst_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word(imem_addr);
    sb.push_back(word(a));
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    chk("valid_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("valid_req_low", {31'b0, imem_req}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst", inst, e);
    end
  endtask

  initial begin
    vecs[0]  = '{PC_SOURCE_NEXT,   1'b1, 32'hDEAD_BEE0, 32'h0,         32'h0040_0004, 0};
    vecs[1]  = '{PC_SOURCE_NEXT,   1'b0, 32'h0,         32'h0,         32'h0040_0008, 3};
    vecs[2]  = '{PC_SOURCE_NEXT,   1'b0, 32'h0,         32'h0,         32'h0040_000C, 1};
    vecs[3]  = '{PC_SOURCE_NEXT,   1'b0, 32'h0,         32'h0,         32'h0040_0010, 0};
    vecs[4]  = '{PC_SOURCE_BRANCH, 1'b0, 32'h0040_0000, 32'h0,         32'h0040_0014, 0};
    vecs[5]  = '{PC_SOURCE_JALR,   1'b0, 32'h0,         32'h0040_0011, 32'h0040_0010, 0};
    vecs[6]  = '{PC_SOURCE_BRANCH, 1'b1, 32'h0040_0000, 32'h0,         32'h0040_0000, 2};
    vecs[7]  = '{PC_SOURCE_JAL,    1'b0, 32'h0040_0100, 32'h0,         32'h0040_0100, 0};
    vecs[8]  = '{PC_SOURCE_JALR,   1'b0, 32'h0,         32'h0040_0021, 32'h0040_0020, 0};
    vecs[9]  = '{PC_SOURCE_JAL,    1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 0};
    vecs[10] = '{PC_SOURCE_NEXT,   1'b0, 32'h0,         32'h0,         32'h0000_0000, 0};

    reset_n = 1'b0;
    take_branch = 1'b0;
    pc_source = PC_SOURCE_NEXT;
    branch_target = 32'h0;
    jalr_target = 32'h0;
    retire = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_trap", {31'b0, misaligned_trap}, 32'd0);

    reset_n = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    chk("first_inst_still_0", inst, 32'h0);
    serve(0, 32'h0040_0000);

    for (int i = 0; i < 11; i++) begin
      pc_source = vecs[i].src;
      take_branch = vecs[i].take;
      branch_target = vecs[i].bt;
      jalr_target = vecs[i].jt;
      retire = 1'b1;
      step();
      retire = 1'b0;
      chk($sformatf("v%0d_valid_drop", i), {31'b0, inst_valid}, 32'd0);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp);
      serve(vecs[i].delay, vecs[i].exp);
      chk($sformatf("v%0d_pc4", i), pc_plus_4, vecs[i].exp + 32'd4);
    end

    // Now VALID at 0x0; retire into REQ at 0x4, then retire outside VALID.
    pc_source = PC_SOURCE_NEXT;
    retire = 1'b1;
    step();
    pc_source = PC_SOURCE_JAL;
    branch_target = 32'h1234_0000;
    step();
    step();
    retire = 1'b0;
    chk("retire_req_ignored", imem_addr, 32'h0000_0004);
    chk("retire_req_pc", pc, 32'h0000_0004);
    chk("retire_req_req", {31'b0, imem_req}, 32'd1);

    // Async reset mid-REQ while memory returns data.
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    #1 reset_n = 1'b0;
    #1;
    chk("async_req_drop", {31'b0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0040_0000);
    step();
    chk("async_inst_discard", inst, 32'h0);
    chk("async_valid", {31'b0, inst_valid}, 32'd0);
    imem_ready = 1'b0;
    reset_n = 1'b1;
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("idle_retire_pc", imem_addr, 32'h0040_0000);
    chk("idle_retire_req", {31'b0, imem_req}, 32'd1);
    serve(0, 32'h0040_0000);

    // Misaligned JALR target halts the fetch unit.
    pc_source = PC_SOURCE_JALR;
    jalr_target = 32'h0040_0022;
    retire = 1'b1;
    step();
    chk("trap_set", {31'b0, misaligned_trap}, 32'd1);
    chk("trap_pc_hold", pc, 32'h0040_0000);
    chk("trap_req", {31'b0, imem_req}, 32'd0);
    chk("trap_valid", {31'b0, inst_valid}, 32'd0);
    pc_source = PC_SOURCE_NEXT;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      retire = i[0];
      step();
      chk($sformatf("halt%0d_req", i), {31'b0, imem_req}, 32'd0);
      chk($sformatf("halt%0d_trap", i), {31'b0, misaligned_trap}, 32'd1);
      chk($sformatf("halt%0d_pc", i), pc, 32'h0040_0000);
    end
    retire = 1'b0;
    imem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
